// File: rtl/systolic_feeder.sv
// Input skew feeder for an N x N systolic matrix-multiply array: buffers one A
// (row per beat) and one B (column per beat), then drives the skewed array edges.
module systolic_feeder #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_a,
   input  logic [N*DATA_WIDTH-1:0] in_b,
   output logic [N*DATA_WIDTH-1:0] a_edge,
   output logic [N*DATA_WIDTH-1:0] b_edge,
   output logic                    array_en,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              fsm_state
);

   localparam int W  = N * DATA_WIDTH;
   localparam int TW = $clog2(3 * N + 1);
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0] CNT_LAST     = CW'(N - 1);
   localparam logic [TW-1:0] T_FEED_END   = TW'(2 * N - 2);
   localparam logic [TW-1:0] T_EN_LAST    = TW'(3 * N - 3);
   localparam logic [TW-1:0] T_FLUSH_END  = TW'(3 * N - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_FEED  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [TW-1:0]   t;
   logic [TW-1:0]   t_nxt;
   logic [CW-1:0]   load_cnt;
   logic [W-1:0]    a_buf [N];
   logic [W-1:0]    b_buf [N];
   logic [W-1:0]    a_nxt;
   logic [W-1:0]    b_nxt;
   logic            accept;

   // Handshake: a load beat transfers on a rising clk edge where in_valid and
   // in_ready are both high; in_ready is a register and never looks at in_valid.
   assign accept    = in_valid && in_ready;
   assign fsm_state = state;

   // a_buf[k] holds row k of A, b_buf[k] holds column k of B; never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_buf[load_cnt] <= in_a;
         b_buf[load_cnt] <= in_b;
      end
   end

   // Edge values for the cycle being entered: lane i shows element t-i of its
   // buffered row/column, zero outside the diagonal band.
   always_comb begin
      t_nxt = (state == S_LOAD) ? '0 : t + 1'b1;
      a_nxt = '0;
      b_nxt = '0;
      for (int i = 0; i < N; i++) begin
         for (int m = 0; m < N; m++) begin
            if (int'(t_nxt) == i + m) begin
               a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][m*DATA_WIDTH +: DATA_WIDTH];
               b_nxt[i*DATA_WIDTH +: DATA_WIDTH] = b_buf[i][m*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_LOAD;
         t        <= '0;
         load_cnt <= '0;
         in_ready <= 1'b0;
         a_edge   <= '0;
         b_edge   <= '0;
         array_en <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (load_cnt == CNT_LAST) begin
                     state    <= S_FEED;
                     load_cnt <= '0;
                     t        <= '0;
                     in_ready <= 1'b0;
                     a_edge   <= a_nxt;
                     b_edge   <= b_nxt;
                     array_en <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     load_cnt <= load_cnt + 1'b1;
                  end
               end
            end
            S_FEED: begin
               t        <= t_nxt;
               a_edge   <= a_nxt;
               b_edge   <= b_nxt;
               array_en <= (t_nxt <= T_EN_LAST);
               if (t == T_FEED_END) state <= S_FLUSH;
            end
            S_FLUSH: begin
               t        <= t_nxt;
               a_edge   <= '0;
               b_edge   <= '0;
               array_en <= (t_nxt <= T_EN_LAST);
               if (t == T_FLUSH_END) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state    <= S_LOAD;
               t        <= '0;
               done     <= 1'b0;
               in_ready <= 1'b1;
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a spec-level edge/handshake model plus a small
// PE-grid model fed from the DUT edges, compared on every negedge.
module tb_systolic_feeder;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int W  = N * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [W-1:0]  a_edge;
   logic [W-1:0]  b_edge;
   logic          array_en;
   logic          busy;
   logic          done;
   logic [1:0]    fsm_state;

   int n_tests = 0;
   int n_fail  = 0;

   systolic_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .a_edge    (a_edge),
      .b_edge    (b_edge),
      .array_en  (array_en),
      .busy      (busy),
      .done      (done),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h required 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- protocol / edge model ----------------
   // m_t = -1 while loading, otherwise the job-relative cycle number 0..3N.
   int m_t     = -1;
   int m_cnt   = 0;
   bit m_ready = 1'b0;
   int m_a [N][N];
   int m_b [N][N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t     <= -1;
         m_cnt   <= 0;
         m_ready <= 1'b0;
      end else if (m_t < 0) begin
         m_ready <= 1'b1;
         if (in_valid && m_ready) begin
            for (int m = 0; m < N; m++) begin
               m_a[m_cnt][m] <= int'(in_a[m*DW +: DW]);
               m_b[m][m_cnt] <= int'(in_b[m*DW +: DW]);
            end
            if (m_cnt == N - 1) begin
               m_t     <= 0;
               m_cnt   <= 0;
               m_ready <= 1'b0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end else if (m_t == 3 * N) begin
         m_t     <= -1;
         m_ready <= 1'b1;
      end else begin
         m_t <= m_t + 1;
      end
   end

   // ---------------- PE grid fed by the DUT edges ----------------
   logic [DW-1:0] pa [N][N];
   logic [DW-1:0] pb [N][N];
   longint        pm [N][N];
   longint        pc [N][N];
   logic          en_d1, en_d2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d1 <= 1'b0;
         en_d2 <= 1'b0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               pa[i][j] <= '0;
               pb[i][j] <= '0;
               pm[i][j] <= 0;
               pc[i][j] <= 0;
            end
      end else begin
         en_d1 <= array_en;
         en_d2 <= en_d1;
         if (array_en) begin
            for (int i = 0; i < N; i++) begin
               pa[i][0] <= a_edge[i*DW +: DW];
               pb[0][i] <= b_edge[i*DW +: DW];
               for (int j = 1; j < N; j++) begin
                  pa[i][j] <= pa[i][j-1];
                  pb[j][i] <= pb[j-1][i];
               end
            end
         end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               if (en_d1) pm[i][j] <= longint'(pa[i][j]) * longint'(pb[i][j]);
               if (en_d2) pc[i][j] <= pc[i][j] + pm[i][j];
            end
      end
   end

   function automatic longint prod(input int i, input int j);
      longint s = 0;
      for (int m = 0; m < N; m++) s += longint'(m_a[i][m]) * longint'(m_b[m][j]);
      return s;
   endfunction

   // ---------------- compare process ----------------
   longint c_base [N][N];

   always @(negedge clk) begin : cmp
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      int           bad;
      if (!rst_n)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c_base[i][j] = 0;
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++)
         for (int m = 0; m < N; m++)
            if (m_t >= 0 && m_t == i + m) begin
               ea[i*DW +: DW] = DW'(m_a[i][m]);
               eb[i*DW +: DW] = DW'(m_b[m][i]);
            end
      chk("in_ready", in_ready, m_ready);
      chk("busy",     busy,     m_t >= 0 && m_t <= 3 * N - 1);
      chk("done",     done,     m_t == 3 * N);
      chk("array_en", array_en, m_t >= 0 && m_t <= 3 * N - 3);
      chk("a_edge",   a_edge,   ea);
      chk("b_edge",   b_edge,   eb);
      bad = 0;
      if (m_t == 3 * N) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (pc[i][j] != c_base[i][j] + prod(i, j)) bad++;
         chk("c_at_done_bad_pes", bad, 0);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c_base[i][j] = c_base[i][j] + prod(i, j);
      end else if (m_t < 0) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (pc[i][j] != c_base[i][j]) bad++;
         chk("c_idle_bad_pes", bad, 0);
      end
   end

   // ---------------- driver tasks ----------------
   int ja [N][N];
   int jb [N][N];
   logic [W-1:0] a_hist [64];
   logic [W-1:0] b_hist [64];

   function automatic logic [W-1:0] row_a(input int k);
      logic [W-1:0] r = '0;
      for (int m = 0; m < N; m++) r[m*DW +: DW] = DW'(ja[k][m]);
      return r;
   endfunction

   function automatic logic [W-1:0] col_b(input int k);
      logic [W-1:0] r = '0;
      for (int m = 0; m < N; m++) r[m*DW +: DW] = DW'(jb[m][k]);
      return r;
   endfunction

   task automatic fill_const(input int av, input int bv);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ja[i][j] = av;
            jb[i][j] = bv;
         end
   endtask

   function automatic int c_bad_const(input longint v);
      int bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (pc[i][j] != v) bad++;
      return bad;
   endfunction

   function automatic int c_bad_ident();
      int bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (pc[i][j] != longint'(i + 4 * j)) bad++;
      return bad;
   endfunction

   // Called #1 after a posedge; returns #1 after the edge that took the last beat.
   task automatic load_job(output int first_wait);
      bit rdy;
      int waited;
      first_wait = 0;
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b1;
         in_a     = row_a(k);
         in_b     = col_b(k);
         waited   = 0;
         do begin
            @(negedge clk) rdy = in_ready;
            @(posedge clk);
            #1;
            waited++;
         end while (!rdy && waited < 200);
         chk("load_beat_accepted", rdy, 1'b1);
         if (k == 0) first_wait = waited;
      end
      in_valid = 1'b0;
   endtask

   // Returns at the negedge of the done cycle; lat counts edges from the
   // accepting edge of the last beat (inclusive).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         a_hist[c] = a_edge;
         b_hist[c] = b_edge;
         if (done) begin
            lat = c + 1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int lat;
      int fw;
      int cnt;
      bit rdy;
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_array_en", array_en, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // skew pattern A[i][k] = 16i+k, B[k][j] = 16k+j
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ja[i][j] = 16 * i + j;
            jb[i][j] = 16 * i + j;
         end
      load_job(fw);
      wait_done(lat);
      chk("skew_latency", lat, 13);
      chk("skew_a_t0", a_hist[0], 32'h0000_0000);
      chk("skew_b_t0", b_hist[0], 32'h0000_0000);
      chk("skew_a_t3", a_hist[3], 32'h3021_1203);
      chk("skew_b_t3", b_hist[3], 32'h0312_2130);
      chk("skew_a_t6", a_hist[6], 32'h3300_0000);
      chk("skew_b_t6", b_hist[6], 32'h3300_0000);
      @(posedge clk);
      #1;

      // all 2 x all 3
      do_reset();
      fill_const(2, 3);
      load_job(fw);
      wait_done(lat);
      chk("c2x3_latency", lat, 13);
      chk("c2x3_bad_pes", c_bad_const(24), 0);
      @(posedge clk);
      #1;

      // all 255 x all 255
      do_reset();
      fill_const(255, 255);
      load_job(fw);
      wait_done(lat);
      chk("cmax_bad_pes", c_bad_const(260100), 0);
      @(posedge clk);
      #1;

      // identity x B with gapped in_valid
      do_reset();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ja[i][j] = (i == j) ? 1 : 0;
            jb[i][j] = i + 4 * j;
         end
      cnt = 0;
      for (int s = 0; s < 7; s++) begin
         in_valid = pat[s][0];
         in_a     = row_a(cnt);
         in_b     = col_b(cnt);
         @(negedge clk) rdy = in_ready;
         @(posedge clk);
         #1;
         if (pat[s] == 1 && rdy) cnt++;
      end
      in_valid = 1'b0;
      chk("gap_beats", cnt, 4);
      wait_done(lat);
      chk("ident_latency", lat, 13);
      chk("ident_bad_pes", c_bad_ident(), 0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("ident_hold_bad_pes", c_bad_ident(), 0);
      end
      @(posedge clk);
      #1;

      // back-to-back without reset, second load held valid through FEED/FLUSH/DONE
      do_reset();
      fill_const(1, 1);
      load_job(fw);
      fill_const(2, 3);
      load_job(fw);
      chk("b2b_first_beat_wait", fw, 14);
      wait_done(lat);
      chk("b2b_latency", lat, 13);
      chk("b2b_sum_bad_pes", c_bad_const(28), 0);
      @(posedge clk);
      #1;

      // reset during FEED at t = 2
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ja[i][j] = 16 * i + j;
            jb[i][j] = 16 * i + j;
         end
      load_job(fw);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_a_edge", a_edge, '0);
      chk("abort_b_edge", b_edge, '0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_array_en", array_en, 1'b0);
      chk("abort_in_ready", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_ready_after_release", in_ready, 1'b1);
      @(posedge clk);
      #1;
      fill_const(1, 2);
      load_job(fw);
      wait_done(lat);
      chk("abort_new_latency", lat, 13);
      chk("abort_new_bad_pes", c_bad_const(8), 0);
      @(posedge clk);
      #1;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
